// File: rtl/tx_axis_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the 10G TX MAC AXIS slave port.
// A granted source keeps the port until its tlast beat is accepted. A source
// that goes silent mid-frame is aborted by a zero-keep tlast beat to the MAC,
// after which the rest of its frame is drained and discarded.
module tx_axis_frame_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                 tx_clk,
  input  logic                                 tx_rst,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] in_s_tx_tdata,
  input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] in_s_tx_tkeep,
  input  logic [NUM_PORTS-1:0]                 in_s_tx_tvalid,
  input  logic [NUM_PORTS-1:0]                 in_s_tx_tlast,
  output logic [NUM_PORTS-1:0]                 out_s_tx_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           out_m_tx_tdata,
  output logic [AXIS_DATA_BYTES-1:0]           out_m_tx_tkeep,
  output logic                                 out_m_tx_tvalid,
  output logic                                 out_m_tx_tlast,
  input  logic                                 in_m_tx_tready,
  input  logic                                 in_pause,
  output logic [NUM_PORTS-1:0]                 out_grant,
  output logic                                 out_busy,
  output logic                                 out_abort
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // A zero timeout still needs a one-bit counter to keep the widths legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  // The abort fires on the edge where the idle count would reach the timeout.
  localparam int STALL_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     g_reg;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [CNT_W-1:0]     idle_cnt_reg;
  logic [NUM_PORTS-1:0] grant_reg;
  logic                 busy_reg;
  logic                 abort_reg;

  // Granted-port view of the source bundle
  logic [AXIS_DATA_WIDTH-1:0] sel_data;
  logic [AXIS_DATA_BYTES-1:0] sel_keep;
  logic                       sel_valid;
  logic                       sel_last;

  // Round-robin pick
  logic [NUM_PORTS-1:0] hi_mask;
  logic [NUM_PORTS-1:0] req_hi;
  logic [NUM_PORTS-1:0] pick_src;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_PORTS-1:0] pick_onehot;

  logic [CNT_W-1:0]     idle_cnt_next;
  logic                 stall_hit;

  // Ports strictly above the last winner get first refusal; the rest wrap.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rr
      assign hi_mask[gi]     = (IDX_W'(gi) > rr_ptr_reg);
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
    end
  endgenerate

  assign req_hi   = in_s_tx_tvalid & hi_mask;
  assign pick_src = (|req_hi) ? req_hi : in_s_tx_tvalid;

  // Lowest-numbered requester in the chosen half of the rotation wins
  always_comb begin
    pick_idx = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (pick_src[p]) begin
        pick_idx = IDX_W'(p);
      end
    end
  end

  // Select the granted port's beat from the packed source bundles
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (g_reg == IDX_W'(p)) begin
        sel_data  = in_s_tx_tdata[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        sel_keep  = in_s_tx_tkeep[p*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
        sel_valid = in_s_tx_tvalid[p];
        sel_last  = in_s_tx_tlast[p];
      end
    end
  end

  // Saturating idle count; backpressure never reaches this path
  assign idle_cnt_next = (idle_cnt_reg == CNT_W'(CNT_MAX)) ? idle_cnt_reg
                                                           : idle_cnt_reg + CNT_W'(1);
  assign stall_hit = WDOG_EN && (idle_cnt_reg >= CNT_W'(STALL_LIMIT));

  // Arbitration FSM with registered grant, busy and abort outputs
  always_ff @(posedge tx_clk or negedge tx_rst) begin
    if (!tx_rst) begin
      state_reg    <= IDLE;
      g_reg        <= '0;
      rr_ptr_reg   <= IDX_W'(NUM_PORTS - 1);
      idle_cnt_reg <= '0;
      grant_reg    <= '0;
      busy_reg     <= 1'b0;
      abort_reg    <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!in_pause && (|in_s_tx_tvalid)) begin
            state_reg    <= ACTIVE;
            g_reg        <= pick_idx;
            rr_ptr_reg   <= pick_idx;
            idle_cnt_reg <= '0;
            grant_reg    <= pick_onehot;
            busy_reg     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (sel_valid && in_m_tx_tready) begin
            idle_cnt_reg <= '0;
            if (sel_last) begin
              state_reg <= IDLE;
              grant_reg <= '0;
              busy_reg  <= 1'b0;
            end
          end else if (!sel_valid && WDOG_EN) begin
            idle_cnt_reg <= idle_cnt_next;
            if (stall_hit) begin
              state_reg <= FLUSH;
              abort_reg <= 1'b1;
            end
          end
        end
        FLUSH: begin
          // Hold the terminating beat until the MAC takes it
          if (in_m_tx_tready) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (sel_valid && sel_last) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational datapath and per-port tready steering by state
  always_comb begin
    out_m_tx_tdata  = '0;
    out_m_tx_tkeep  = '0;
    out_m_tx_tvalid = 1'b0;
    out_m_tx_tlast  = 1'b0;
    out_s_tx_tready = '0;
    case (state_reg)
      ACTIVE: begin
        out_m_tx_tdata  = sel_data;
        out_m_tx_tkeep  = sel_keep;
        out_m_tx_tvalid = sel_valid;
        out_m_tx_tlast  = sel_last;
        out_s_tx_tready = grant_reg & {NUM_PORTS{in_m_tx_tready}};
      end
      FLUSH: begin
        // Zero-keep tlast closes the MAC frame without adding payload bytes
        out_m_tx_tvalid = 1'b1;
        out_m_tx_tlast  = 1'b1;
      end
      DRAIN: begin
        out_s_tx_tready = grant_reg;
      end
      default: begin
      end
    endcase
  end

  assign out_grant = grant_reg;
  assign out_busy  = busy_reg;
  assign out_abort = abort_reg;

endmodule

// File: tb/tb_tx_axis_frame_arbiter.sv
// Bench for tx_axis_frame_arbiter: random frames driven from per-port queues,
// a cycle-level behavioural model of the arbitration rules, and per-scenario
// checks of grant order, MAC output stream, abort pulses and reset behaviour.
`timescale 1ns/1ps
module tb_tx_axis_frame_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int B = 4;
  localparam int T = 8;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_FLUSH  = 2;
  localparam int M_DRAIN  = 3;

  logic           tx_clk = 1'b0;
  logic           tx_rst = 1'b0;
  logic [N*W-1:0] in_s_tx_tdata;
  logic [N*B-1:0] in_s_tx_tkeep;
  logic [N-1:0]   in_s_tx_tvalid;
  logic [N-1:0]   in_s_tx_tlast;
  logic [N-1:0]   out_s_tx_tready;
  logic [W-1:0]   out_m_tx_tdata;
  logic [B-1:0]   out_m_tx_tkeep;
  logic           out_m_tx_tvalid;
  logic           out_m_tx_tlast;
  logic           in_m_tx_tready;
  logic           in_pause;
  logic [N-1:0]   out_grant;
  logic           out_busy;
  logic           out_abort;

  tx_axis_frame_arbiter #(
    .NUM_PORTS(N), .AXIS_DATA_WIDTH(W), .AXIS_DATA_BYTES(B), .TIMEOUT_CYCLES(T)
  ) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .in_s_tx_tdata(in_s_tx_tdata), .in_s_tx_tkeep(in_s_tx_tkeep),
    .in_s_tx_tvalid(in_s_tx_tvalid), .in_s_tx_tlast(in_s_tx_tlast),
    .out_s_tx_tready(out_s_tx_tready),
    .out_m_tx_tdata(out_m_tx_tdata), .out_m_tx_tkeep(out_m_tx_tkeep),
    .out_m_tx_tvalid(out_m_tx_tvalid), .out_m_tx_tlast(out_m_tx_tlast),
    .in_m_tx_tready(in_m_tx_tready), .in_pause(in_pause),
    .out_grant(out_grant), .out_busy(out_busy), .out_abort(out_abort)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [B-1:0] keep;
    logic         last;
  } beat_t;

  beat_t srcq [N][$];
  beat_t mac_log [$];
  int    grant_log [$];
  int    abort_cnt;
  int    mdl_err;
  string first_err;
  int    n_tests;
  int    n_fail;
  bit    rand_ready;
  logic [N-1:0] prev_grant;

  // Behavioural model state
  int m_state;
  int m_g;
  int m_rr;
  int m_idle;
  bit m_abort;

  task automatic note_err(input string what);
    if (mdl_err == 0) first_err = $sformatf("t=%0t %s", $time, what);
    mdl_err++;
  endtask

  task automatic drive_idle();
    in_s_tx_tdata  = '0;
    in_s_tx_tkeep  = '0;
    in_s_tx_tvalid = '0;
    in_s_tx_tlast  = '0;
  endtask

  task automatic start_scenario();
    mac_log.delete();
    grant_log.delete();
    abort_cnt = 0;
    mdl_err   = 0;
    first_err = "";
  endtask

  task automatic apply_reset();
    @(negedge tx_clk);
    tx_rst = 1'b0;
    drive_idle();
    in_pause       = 1'b0;
    rand_ready     = 1'b0;
    in_m_tx_tready = 1'b1;
    for (int p = 0; p < N; p++) srcq[p].delete();
    m_state = M_IDLE; m_g = 0; m_rr = N - 1; m_idle = 0; m_abort = 1'b0;
    prev_grant = '0;
    repeat (2) @(negedge tx_clk);
    tx_rst = 1'b1;
    start_scenario();
  endtask

  task automatic make_frame(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = W'($urandom);
      if (i == len - 1) begin
        b.keep = B'($urandom_range(1, 15));
        b.last = 1'b1;
      end else begin
        b.keep = '1;
        b.last = 1'b0;
      end
      srcq[p].push_back(b);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, update model at posedge
  task automatic cycle();
    logic [N-1:0] vld, hs, exp_rdy, exp_grant;
    logic         exp_valid, exp_last, mac_hs, found;
    logic [W-1:0] exp_data;
    logic [B-1:0] exp_keep;
    beat_t        b;
    int           idx;
    for (int p = 0; p < N; p++) begin
      if (srcq[p].size() > 0) begin
        vld[p] = 1'b1;
        in_s_tx_tdata[p*W +: W] = srcq[p][0].data;
        in_s_tx_tkeep[p*B +: B] = srcq[p][0].keep;
        in_s_tx_tlast[p]        = srcq[p][0].last;
      end else begin
        vld[p] = 1'b0;
        in_s_tx_tdata[p*W +: W] = '0;
        in_s_tx_tkeep[p*B +: B] = '0;
        in_s_tx_tlast[p]        = 1'b0;
      end
    end
    in_s_tx_tvalid = vld;
    in_m_tx_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    exp_rdy = '0; exp_grant = '0; exp_valid = 1'b0; exp_last = 1'b0;
    exp_data = '0; exp_keep = '0;
    if (m_state == M_ACTIVE) begin
      exp_rdy[m_g]   = in_m_tx_tready;
      exp_grant[m_g] = 1'b1;
      exp_valid      = vld[m_g];
      exp_data       = in_s_tx_tdata[m_g*W +: W];
      exp_keep       = in_s_tx_tkeep[m_g*B +: B];
      exp_last       = in_s_tx_tlast[m_g];
    end else if (m_state == M_FLUSH) begin
      exp_valid = 1'b1;
      exp_last  = 1'b1;
    end else if (m_state == M_DRAIN) begin
      exp_rdy[m_g] = 1'b1;
    end
    if (out_s_tx_tready !== exp_rdy)
      note_err($sformatf("tready got %b want %b", out_s_tx_tready, exp_rdy));
    if (out_m_tx_tvalid !== exp_valid)
      note_err($sformatf("m_tvalid got %b want %b", out_m_tx_tvalid, exp_valid));
    if (out_busy !== (m_state != M_IDLE))
      note_err($sformatf("busy got %b model state %0d", out_busy, m_state));
    if (out_abort !== m_abort)
      note_err($sformatf("abort got %b want %b", out_abort, m_abort));
    if ((m_state == M_IDLE || m_state == M_ACTIVE) && out_grant !== exp_grant)
      note_err($sformatf("grant got %b want %b", out_grant, exp_grant));
    if ((m_state == M_ACTIVE || m_state == M_FLUSH) &&
        {out_m_tx_tdata, out_m_tx_tkeep, out_m_tx_tlast} !== {exp_data, exp_keep, exp_last})
      note_err($sformatf("m_beat got %h/%h/%b want %h/%h/%b", out_m_tx_tdata,
               out_m_tx_tkeep, out_m_tx_tlast, exp_data, exp_keep, exp_last));
    // Observations logged for the scenario-level checks
    mac_hs = out_m_tx_tvalid && in_m_tx_tready;
    if (mac_hs) begin
      b.data = out_m_tx_tdata; b.keep = out_m_tx_tkeep; b.last = out_m_tx_tlast;
      mac_log.push_back(b);
      if (out_m_tx_tlast)
        $display("[TB] t=%0t MAC frame closed: grant=%b keep=%h beats_so_far=%0d",
                 $time, out_grant, out_m_tx_tkeep, mac_log.size());
    end
    if (out_abort) abort_cnt++;
    if (out_grant != '0 && prev_grant == '0) begin
      idx = -1;
      for (int p = 0; p < N; p++) if (out_grant[p]) idx = p;
      grant_log.push_back(idx);
    end
    prev_grant = out_grant;
    hs = vld & out_s_tx_tready;
    @(posedge tx_clk);
    m_abort = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (!in_pause && vld != '0) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            idx = (m_rr + k) % N;
            if (!found && vld[idx]) begin
              m_g = idx;
              found = 1'b1;
            end
          end
          m_rr = m_g; m_idle = 0; m_state = M_ACTIVE;
        end
      end
      M_ACTIVE: begin
        if (vld[m_g] && in_m_tx_tready) begin
          m_idle = 0;
          if (in_s_tx_tlast[m_g]) m_state = M_IDLE;
        end else if (!vld[m_g]) begin
          m_idle++;
          if (m_idle >= T) begin
            m_state = M_FLUSH;
            m_abort = 1'b1;
          end
        end
      end
      M_FLUSH: if (in_m_tx_tready) m_state = M_DRAIN;
      default: if (vld[m_g] && in_s_tx_tlast[m_g]) m_state = M_IDLE;
    endcase
    for (int p = 0; p < N; p++) if (hs[p]) void'(srcq[p].pop_front());
    @(negedge tx_clk);
  endtask

  task automatic run_drain(input int max_cycles, output bit timed_out);
    int c;
    bit pending;
    c = 0;
    pending = 1'b1;
    while (pending && c < max_cycles) begin
      cycle();
      c++;
      pending = (m_state != M_IDLE);
      for (int p = 0; p < N; p++) if (srcq[p].size() > 0) pending = 1'b1;
    end
    timed_out = pending;
    cycle();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++; if (out_grant !== '0) begin n_fail++; $display("FAIL reset_grant got %b want 0", out_grant); end
    n_tests++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", out_busy); end
    n_tests++; if (out_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort got %b want 0", out_abort); end
    n_tests++; if (out_s_tx_tready !== '0) begin n_fail++; $display("FAIL reset_tready got %b want 0", out_s_tx_tready); end
    n_tests++; if (out_m_tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", out_m_tx_tvalid); end
    n_tests++; if (out_m_tx_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b want 0", out_m_tx_tlast); end
    n_tests++; if (out_m_tx_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", out_m_tx_tdata); end
    n_tests++; if (out_m_tx_tkeep !== '0) begin n_fail++; $display("FAIL reset_tkeep got %h want 0", out_m_tx_tkeep); end
    @(negedge tx_clk);
  endtask

  task automatic test_two_ports();
    beat_t exp_q [$];
    bit    to;
    int    diffs;
    apply_reset();
    make_frame(0, 16);
    make_frame(2, 16);
    for (int i = 0; i < srcq[0].size(); i++) exp_q.push_back(srcq[0][i]);
    for (int i = 0; i < srcq[2].size(); i++) exp_q.push_back(srcq[2][i]);
    run_drain(200, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL two_ports_timeout got pending want drained"); end
    n_tests++; if (mdl_err !== 0) begin n_fail++; $display("FAIL two_ports_model errors=%0d want 0 (%s)", mdl_err, first_err); end
    n_tests++;
    if (grant_log.size() !== 2 || grant_log[0] !== 0 || grant_log[1] !== 2) begin
      n_fail++; $display("FAIL two_ports_order got %p want '{0,2}", grant_log);
    end
    diffs = (mac_log.size() > exp_q.size()) ? mac_log.size() - exp_q.size() : exp_q.size() - mac_log.size();
    for (int i = 0; i < mac_log.size() && i < exp_q.size(); i++) if (mac_log[i] !== exp_q[i]) diffs++;
    n_tests++; if (diffs !== 0) begin n_fail++; $display("FAIL two_ports_stream bad_beats=%0d got_len=%0d want_len=%0d", diffs, mac_log.size(), exp_q.size()); end
  endtask

  task automatic test_round_robin();
    beat_t exp_q [$];
    bit    to;
    int    diffs;
    int    want [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    apply_reset();
    for (int p = 0; p < N; p++) begin
      make_frame(p, 3);
      make_frame(p, 3);
    end
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++)
        for (int i = 0; i < 3; i++) exp_q.push_back(srcq[p][r*3 + i]);
    run_drain(300, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rr_timeout got pending want drained"); end
    n_tests++; if (mdl_err !== 0) begin n_fail++; $display("FAIL rr_model errors=%0d want 0 (%s)", mdl_err, first_err); end
    diffs = (grant_log.size() == 8) ? 0 : 1;
    for (int i = 0; i < grant_log.size() && i < 8; i++) if (grant_log[i] !== want[i]) diffs++;
    n_tests++; if (diffs !== 0) begin n_fail++; $display("FAIL rr_order got %p want 0,1,2,3,0,1,2,3", grant_log); end
    diffs = (mac_log.size() > exp_q.size()) ? mac_log.size() - exp_q.size() : exp_q.size() - mac_log.size();
    for (int i = 0; i < mac_log.size() && i < exp_q.size(); i++) if (mac_log[i] !== exp_q[i]) diffs++;
    n_tests++; if (diffs !== 0) begin n_fail++; $display("FAIL rr_stream bad_beats=%0d got_len=%0d want_len=%0d", diffs, mac_log.size(), exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit to;
    apply_reset();
    // Single-beat frames: tlast on the first beat, same port three times
    make_frame(2, 1);
    make_frame(2, 1);
    make_frame(2, 1);
    run_drain(60, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout got pending want drained"); end
    n_tests++; if (mdl_err !== 0) begin n_fail++; $display("FAIL b2b_model errors=%0d want 0 (%s)", mdl_err, first_err); end
    n_tests++;
    if (grant_log.size() !== 3 || grant_log[0] !== 2 || grant_log[1] !== 2 || grant_log[2] !== 2) begin
      n_fail++; $display("FAIL b2b_grants got %p want three separate grants of port 2", grant_log);
    end
    n_tests++; if (mac_log.size() !== 3) begin n_fail++; $display("FAIL b2b_beats got %0d want 3", mac_log.size()); end
  endtask

  task automatic test_backpressure();
    beat_t exp_q [$];
    bit    to;
    int    diffs;
    apply_reset();
    rand_ready = 1'b1;
    make_frame(1, 20);
    for (int i = 0; i < srcq[1].size(); i++) exp_q.push_back(srcq[1][i]);
    run_drain(400, to);
    rand_ready = 1'b0;
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got pending want drained"); end
    n_tests++; if (mdl_err !== 0) begin n_fail++; $display("FAIL bp_model errors=%0d want 0 (%s)", mdl_err, first_err); end
    n_tests++; if (abort_cnt !== 0) begin n_fail++; $display("FAIL bp_abort got %0d pulses want 0", abort_cnt); end
    diffs = (mac_log.size() > exp_q.size()) ? mac_log.size() - exp_q.size() : exp_q.size() - mac_log.size();
    for (int i = 0; i < mac_log.size() && i < exp_q.size(); i++) if (mac_log[i] !== exp_q[i]) diffs++;
    n_tests++; if (diffs !== 0) begin n_fail++; $display("FAIL bp_stream bad_beats=%0d got_len=%0d want_len=20", diffs, mac_log.size()); end
  endtask

  task automatic test_watchdog();
    beat_t first2 [$];
    beat_t flush_b;
    bit    to;
    int    c;
    apply_reset();
    make_frame(3, 5);
    first2.push_back(srcq[3][0]);
    first2.push_back(srcq[3][1]);
    // Hold back the last three words so port 3 goes silent after two beats
    srcq[3].delete();
    srcq[3].push_back(first2[0]);
    srcq[3].push_back(first2[1]);
    c = 0;
    while (srcq[3].size() > 0 && c < 20) begin cycle(); c++; end
    n_tests++; if (srcq[3].size() !== 0) begin n_fail++; $display("FAIL wd_first_words left=%0d want 0", srcq[3].size()); end
    repeat (T) cycle();
    make_frame(3, 3);
    run_drain(100, to);
    flush_b.data = '0; flush_b.keep = '0; flush_b.last = 1'b1;
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL wd_timeout got pending want drained"); end
    n_tests++; if (mdl_err !== 0) begin n_fail++; $display("FAIL wd_model errors=%0d want 0 (%s)", mdl_err, first_err); end
    n_tests++; if (abort_cnt !== 1) begin n_fail++; $display("FAIL wd_abort got %0d pulses want 1", abort_cnt); end
    n_tests++;
    if (mac_log.size() !== 3 || mac_log[0] !== first2[0] || mac_log[1] !== first2[1] || mac_log[2] !== flush_b) begin
      n_fail++; $display("FAIL wd_stream got %0d beats want 2 data + zero-keep tlast", mac_log.size());
    end
    n_tests++; if (out_busy !== 1'b0 || out_grant !== '0) begin n_fail++; $display("FAIL wd_idle busy=%b grant=%b want 0/0", out_busy, out_grant); end
  endtask

  task automatic test_pause();
    bit to;
    int c;
    apply_reset();
    in_pause = 1'b1;
    make_frame(1, 4);
    repeat (6) cycle();
    n_tests++; if (out_busy !== 1'b0 || out_grant !== '0) begin n_fail++; $display("FAIL pause_hold busy=%b grant=%b want 0/0", out_busy, out_grant); end
    n_tests++; if (srcq[1].size() !== 4) begin n_fail++; $display("FAIL pause_words got %0d left want 4", srcq[1].size()); end
    in_pause = 1'b0;
    c = 0;
    while (grant_log.size() == 0 && c < 10) begin cycle(); c++; end
    in_pause = 1'b1;
    make_frame(2, 3);
    repeat (20) cycle();
    n_tests++; if (srcq[1].size() !== 0) begin n_fail++; $display("FAIL pause_inflight got %0d left want 0", srcq[1].size()); end
    n_tests++; if (srcq[2].size() !== 3 || out_busy !== 1'b0) begin n_fail++; $display("FAIL pause_block left=%0d busy=%b want 3/0", srcq[2].size(), out_busy); end
    in_pause = 1'b0;
    run_drain(50, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL pause_timeout got pending want drained"); end
    n_tests++; if (mdl_err !== 0) begin n_fail++; $display("FAIL pause_model errors=%0d want 0 (%s)", mdl_err, first_err); end
    n_tests++;
    if (grant_log.size() !== 2 || grant_log[0] !== 1 || grant_log[1] !== 2) begin
      n_fail++; $display("FAIL pause_order got %p want '{1,2}", grant_log);
    end
  endtask

  task automatic test_async_reset();
    bit to;
    apply_reset();
    make_frame(2, 10);
    repeat (4) cycle();
    n_tests++; if (out_busy !== 1'b1) begin n_fail++; $display("FAIL arst_prebusy got %b want 1", out_busy); end
    #2;
    tx_rst = 1'b0;
    #1;
    n_tests++; if (out_grant !== '0 || out_busy !== 1'b0) begin n_fail++; $display("FAIL arst_grant grant=%b busy=%b want 0/0", out_grant, out_busy); end
    n_tests++; if (out_s_tx_tready !== '0 || out_m_tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL arst_handshake tready=%b tvalid=%b want 0/0", out_s_tx_tready, out_m_tx_tvalid); end
    n_tests++; if (out_m_tx_tdata !== '0 || out_m_tx_tkeep !== '0 || out_m_tx_tlast !== 1'b0) begin n_fail++; $display("FAIL arst_data got %h/%h/%b want 0", out_m_tx_tdata, out_m_tx_tkeep, out_m_tx_tlast); end
    @(negedge tx_clk);
    drive_idle();
    for (int p = 0; p < N; p++) srcq[p].delete();
    m_state = M_IDLE; m_g = 0; m_rr = N - 1; m_idle = 0; m_abort = 1'b0;
    prev_grant = '0;
    @(negedge tx_clk);
    tx_rst = 1'b1;
    start_scenario();
    make_frame(1, 2);
    make_frame(3, 2);
    make_frame(0, 2);
    run_drain(60, to);
    n_tests++; if (to !== 1'b0 || mdl_err !== 0) begin n_fail++; $display("FAIL arst_after pending=%b errors=%0d want 0/0 (%s)", to, mdl_err, first_err); end
    n_tests++;
    if (grant_log.size() !== 3 || grant_log[0] !== 0 || grant_log[1] !== 1 || grant_log[2] !== 3) begin
      n_fail++; $display("FAIL arst_order got %p want '{0,1,3}", grant_log);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rand_ready = 1'b0;
    in_pause = 1'b0;
    in_m_tx_tready = 1'b1;
    drive_idle();
    start_scenario();
    test_reset();
    test_two_ports();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_watchdog();
    test_pause();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit reached at t=%0t, bench did not finish", $time);
    $fatal(1, "time limit");
  end

endmodule
